// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder built from two half-adder stages.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  // First half adder on the operand bits, second folds in the carry.
  always_comb begin
    h1_s = x ^ y;
    h1_c = x & y;
    sum  = h1_s ^ cin;
    h2_c = h1_s & cin;
    cout = h1_c | h2_c;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, WIDTH cycles per add,
// valid/ready handshake on both operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_d;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder_bit u_fa (
    .x    (sa[0]),
    .y    (sb[0]),
    .cin  (c),
    .sum  (fa_s),
    .cout (fa_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state decode: accept in IDLE, leave RUN after the last bit, release on out_ready.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid)     state_d = RUN;
      RUN:     if (cnt == LAST)  state_d = DONE;
      DONE:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and result register; result holds outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      res <= '0;
      c   <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa  <= a;
            sb  <= b;
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          res <= {fa_s, res[WIDTH-1:1]};
          c   <= fa_co;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          // Counter parks on the last index so it never wraps.
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = res;
  assign carry     = c;

endmodule
